als_lux_filter: RTL and testbench

//  Downstream consumer of the ALS PmodALS controller's 8-bit light value.

---
 rtl/als_lux_filter_if.sv | 37 +++
 rtl/als_lux_filter.sv | 149 ++++++++++++++
 tb/tb_als_lux_filter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/als_lux_filter_if.sv
// ----------------------------------------------------------------------------
// als_lux_filter_if
//   Groups the light-value input and the filtered result outputs of the
//   ALS lux filter into one bundle.
//   Signals:
//     i_value      8  light value from the ALS controller
//     o_average    8  window average
//     o_avg_valid  1  one-cycle pulse when o_average / o_bright update
//     o_bright     1  hysteresis flag
//     o_filled     1  window holds a full set of samples
//   Modports:
//     slave   - the filter (consumes i_value, drives the results)
//     master  - the surrounding logic (drives i_value, consumes the results)
// ----------------------------------------------------------------------------
interface als_lux_filter_if;
    logic [7:0] i_value;
    logic [7:0] o_average;
    logic       o_avg_valid;
    logic       o_bright;
    logic       o_filled;

    modport slave (
        input  i_value,
        output o_average,
        output o_avg_valid,
        output o_bright,
        output o_filled
    );

    modport master (
        output i_value,
        input  o_average,
        input  o_avg_valid,
        input  o_bright,
        input  o_filled
    );
endinterface

// File: rtl/als_lux_filter.sv
// ----------------------------------------------------------------------------
// als_lux_filter
//   Decimates the free-running ALS light value to one sample every SAMPLE_DIV
//   clocks, keeps a boxcar average over the last 2^LOG2_DEPTH samples and
//   derives a bright/dark flag with hysteresis from the average.
//   Ports:
//     i_system_clock  in  system clock, rising edge
//     i_aresetn       in  synchronous active-low reset
//     bus             slave side of als_lux_filter_if (value in, results out)
// ----------------------------------------------------------------------------
module als_lux_filter #(
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned LOG2_DEPTH = 3,
    parameter logic [7:0]  TH_HIGH    = 8'd160,
    parameter logic [7:0]  TH_LOW     = 8'd96
) (
    input  logic             i_system_clock,
    input  logic             i_aresetn,
    als_lux_filter_if.slave  bus
);
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int SUM_W  = DATA_W + LOG2_DEPTH;
    localparam int CNT_W  = $clog2(SAMPLE_DIV);
    localparam int FILL_W = LOG2_DEPTH + 1;

    if (SAMPLE_DIV < 4) begin : g_chk_div
        $error("als_lux_filter: SAMPLE_DIV must be >= 4");
    end
    if (LOG2_DEPTH < 1 || LOG2_DEPTH > 4) begin : g_chk_depth
        $error("als_lux_filter: LOG2_DEPTH must be in 1..4");
    end
    if (TH_LOW >= TH_HIGH) begin : g_chk_th
        $error("als_lux_filter: TH_LOW must be below TH_HIGH");
    end

    typedef enum logic [1:0] {
        S_WAIT,
        S_CAPTURE,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       tick_cnt;
    logic                   tick;
    logic [DATA_W-1:0]      value_p0;
    logic [DATA_W-1:0]      sample_p1;
    logic [DATA_W-1:0]      sample_buf [DEPTH];
    logic [SUM_W-1:0]       sum_p2;
    logic [LOG2_DEPTH-1:0]  wr_ptr;
    logic [FILL_W-1:0]      fill_cnt;

    function automatic logic [DATA_W-1:0] window_avg(input logic [SUM_W-1:0] sum);
        window_avg = sum[SUM_W-1:LOG2_DEPTH];
    endfunction

    function automatic logic bright_next(input logic [DATA_W-1:0] avg, input logic prev);
        bright_next = prev;
        if (avg >= TH_HIGH) begin
            bright_next = 1'b1;
        end else if (avg <= TH_LOW) begin
            bright_next = 1'b0;
        end
    endfunction

    // Free-running decimation counter, independent of the FSM.
    assign tick = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge i_system_clock) begin
        if (!i_aresetn) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_system_clock) begin
        if (!i_aresetn) begin
            state <= S_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT:    if (tick) state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_ACCUM;
            S_ACCUM:   state_next = S_OUTPUT;
            S_OUTPUT:  state_next = S_WAIT;
            default:   state_next = S_WAIT;
        endcase
    end

    // Stage p0: input registered every cycle; on the tick edge it holds the tick value.
    always_ff @(posedge i_system_clock) begin
        value_p0 <= bus.i_value;
    end

    // Stage p1: latch the decimated sample.
    always_ff @(posedge i_system_clock) begin
        if (state == S_CAPTURE) begin
            sample_p1 <= value_p0;
        end
    end

    // Stage p2: replace the oldest window entry and update the running sum.
    // Subtract and add in one SUM_W expression so the intermediate never underflows.
    always_ff @(posedge i_system_clock) begin
        if (!i_aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                sample_buf[i] <= '0;
            end
            sum_p2   <= '0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else if (state == S_ACCUM) begin
            sum_p2             <= sum_p2 - SUM_W'(sample_buf[wr_ptr]) + SUM_W'(sample_p1);
            sample_buf[wr_ptr] <= sample_p1;
            wr_ptr             <= wr_ptr + LOG2_DEPTH'(1);
            if (fill_cnt != FILL_W'(DEPTH)) begin
                fill_cnt <= fill_cnt + FILL_W'(1);
            end
        end
    end

    // Stage p3: publish the average once the window is full.
    always_ff @(posedge i_system_clock) begin
        if (!i_aresetn) begin
            bus.o_average   <= '0;
            bus.o_avg_valid <= 1'b0;
            bus.o_bright    <= 1'b0;
            bus.o_filled    <= 1'b0;
        end else begin
            bus.o_avg_valid <= 1'b0;
            if (state == S_OUTPUT && fill_cnt == FILL_W'(DEPTH)) begin
                bus.o_average   <= window_avg(sum_p2);
                bus.o_avg_valid <= 1'b1;
                bus.o_bright    <= bright_next(window_avg(sum_p2), bus.o_bright);
                bus.o_filled    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_als_lux_filter.sv
// ----------------------------------------------------------------------------
// tb_als_lux_filter
//   Self-checking bench for als_lux_filter (SAMPLE_DIV=10, LOG2_DEPTH=2,
//   TH_HIGH=160, TH_LOW=96). A window/queue reference model predicts when
//   averages appear and what they are; scenario tasks compare inline.
// ----------------------------------------------------------------------------
module tb_als_lux_filter;
    localparam int          SAMPLE_DIV = 10;
    localparam int          LOG2_DEPTH = 2;
    localparam int          DEPTH      = 1 << LOG2_DEPTH;
    localparam logic [7:0]  TH_HIGH    = 8'd160;
    localparam logic [7:0]  TH_LOW     = 8'd96;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    als_lux_filter_if bus ();

    als_lux_filter #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .LOG2_DEPTH (LOG2_DEPTH),
        .TH_HIGH    (TH_HIGH),
        .TH_LOW     (TH_LOW)
    ) dut (
        .i_system_clock (clk),
        .i_aresetn      (rstn),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: clock edges since reset release, sample window,
    // pending result, and the predicted outputs after the latest edge.
    int         cyc      = 0;
    int         nsamp    = 0;
    int         pend_at  = -1;
    int         pend_avg = 0;
    int         win[$];
    logic [7:0] exp_avg    = 8'd0;
    logic       exp_valid  = 1'b0;
    logic       exp_bright = 1'b0;
    logic       exp_filled = 1'b0;

    task automatic model_edge();
        int s;
        if (!rstn) begin
            cyc = 0; nsamp = 0; pend_at = -1; win.delete();
            exp_avg = 8'd0; exp_valid = 1'b0; exp_bright = 1'b0; exp_filled = 1'b0;
            return;
        end
        cyc++;
        exp_valid = 1'b0;
        if (cyc == pend_at) begin
            exp_valid  = 1'b1;
            exp_filled = 1'b1;
            exp_avg    = pend_avg[7:0];
            if (pend_avg >= int'(TH_HIGH)) exp_bright = 1'b1;
            else if (pend_avg <= int'(TH_LOW)) exp_bright = 1'b0;
        end
        if (cyc % SAMPLE_DIV == 0) begin
            win.push_back(int'(bus.i_value));
            if (win.size() > DEPTH) void'(win.pop_front());
            nsamp++;
            if (nsamp >= DEPTH) begin
                s = 0;
                foreach (win[k]) s += win[k];
                pend_avg = s / DEPTH;
                pend_at  = cyc + 3;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.i_value = 8'hAA;
        repeat (3) step();
        n_cmp++; if (bus.o_average !== 8'h00) begin n_fail++; $display("FAIL reset_avg got %h want 00", bus.o_average); end
        n_cmp++; if (bus.o_avg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_avg_valid); end
        n_cmp++; if (bus.o_bright !== 1'b0) begin n_fail++; $display("FAIL reset_bright got %b want 0", bus.o_bright); end
        n_cmp++; if (bus.o_filled !== 1'b0) begin n_fail++; $display("FAIL reset_filled got %b want 0", bus.o_filled); end
    endtask

    task automatic test_first_fill();
        int pulses = 0;
        bus.i_value = 8'h55;
        rstn = 1'b1;
        for (int i = 0; i < 43; i++) begin
            step();
            n_cmp++; if (bus.o_avg_valid !== exp_valid) begin n_fail++; $display("FAIL fill_valid cyc=%0d got %b want %b", cyc, bus.o_avg_valid, exp_valid); end
            if (i < 42) begin
                n_cmp++; if (bus.o_filled !== 1'b0) begin n_fail++; $display("FAIL fill_early cyc=%0d got %b want 0", cyc, bus.o_filled); end
            end
            if (bus.o_avg_valid === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL fill_pulses got %0d want 1", pulses); end
        n_cmp++; if (bus.o_average !== 8'h55) begin n_fail++; $display("FAIL fill_avg got %h want 55", bus.o_average); end
        n_cmp++; if (bus.o_bright !== 1'b0) begin n_fail++; $display("FAIL fill_bright got %b want 0", bus.o_bright); end
        n_cmp++; if (bus.o_filled !== 1'b1) begin n_fail++; $display("FAIL fill_filled got %b want 1", bus.o_filled); end
    endtask

    task automatic test_step_up();
        logic [7:0] avgs [4]   = '{8'h71, 8'h8E, 8'hAB, 8'hC8};
        logic       brts [4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
        int k = 0;
        bus.i_value = 8'hC8;
        for (int i = 0; i < 40; i++) begin
            step();
            n_cmp++; if (bus.o_avg_valid !== exp_valid) begin n_fail++; $display("FAIL up_valid cyc=%0d got %b want %b", cyc, bus.o_avg_valid, exp_valid); end
            if (bus.o_avg_valid === 1'b1 && k < 4) begin
                n_cmp++; if (bus.o_average !== avgs[k]) begin n_fail++; $display("FAIL up_avg#%0d got %h want %h", k, bus.o_average, avgs[k]); end
                n_cmp++; if (bus.o_bright !== brts[k]) begin n_fail++; $display("FAIL up_bright#%0d got %b want %b", k, bus.o_bright, brts[k]); end
                k++;
            end
        end
        n_cmp++; if (k != 4) begin n_fail++; $display("FAIL up_count got %0d want 4", k); end
    endtask

    task automatic test_hysteresis();
        int avgs [4] = '{180, 160, 140, 120};
        int k = 0;
        bus.i_value = 8'h78;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.o_avg_valid === 1'b1 && k < 4) begin
                n_cmp++; if (int'(bus.o_average) != avgs[k]) begin n_fail++; $display("FAIL hyst_avg#%0d got %0d want %0d", k, bus.o_average, avgs[k]); end
                n_cmp++; if (bus.o_bright !== 1'b1) begin n_fail++; $display("FAIL hyst_hold#%0d got %b want 1", k, bus.o_bright); end
                k++;
            end
        end
        n_cmp++; if (k != 4) begin n_fail++; $display("FAIL hyst_count got %0d want 4", k); end
        bus.i_value = 8'h00;
        repeat (10) step();
        n_cmp++; if (bus.o_avg_valid !== 1'b1) begin n_fail++; $display("FAIL hyst_fall_valid got %b want 1", bus.o_avg_valid); end
        n_cmp++; if (bus.o_average !== 8'd90) begin n_fail++; $display("FAIL hyst_fall_avg got %0d want 90", bus.o_average); end
        n_cmp++; if (bus.o_bright !== 1'b0) begin n_fail++; $display("FAIL hyst_fall_bright got %b want 0", bus.o_bright); end
    endtask

    task automatic test_full_scale();
        bus.i_value = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            step();
            if (exp_valid) begin
                n_cmp++; if (bus.o_average !== exp_avg) begin n_fail++; $display("FAIL full_avg cyc=%0d got %h want %h", cyc, bus.o_average, exp_avg); end
            end
        end
        n_cmp++; if (bus.o_average !== 8'hFF) begin n_fail++; $display("FAIL full_final got %h want ff", bus.o_average); end
        n_cmp++; if (bus.o_bright !== 1'b1) begin n_fail++; $display("FAIL full_bright got %b want 1", bus.o_bright); end
    endtask

    task automatic test_abort();
        int pulses = 0;
        int guard  = 0;
        while (cyc % SAMPLE_DIV != 0 && guard < 12) begin step(); guard++; end
        // Reset while the sample from this tick is in flight, from a filled state.
        rstn = 1'b0;
        step();
        n_cmp++; if (bus.o_average !== 8'h00) begin n_fail++; $display("FAIL abort_avg got %h want 00", bus.o_average); end
        n_cmp++; if (bus.o_bright !== 1'b0) begin n_fail++; $display("FAIL abort_bright got %b want 0", bus.o_bright); end
        n_cmp++; if (bus.o_filled !== 1'b0) begin n_fail++; $display("FAIL abort_filled got %b want 0", bus.o_filled); end
        n_cmp++; if (bus.o_avg_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", bus.o_avg_valid); end
        // Two fresh ticks of full-scale input, then reset one cycle after the second.
        rstn = 1'b1;
        bus.i_value = 8'hFF;
        while (cyc < 21 && guard < 40) begin step(); guard++; end
        rstn = 1'b0;
        step();
        n_cmp++; if (bus.o_filled !== 1'b0) begin n_fail++; $display("FAIL abort2_filled got %b want 0", bus.o_filled); end
        rstn = 1'b1;
        for (int i = 0; i < 43; i++) begin
            if (cyc % SAMPLE_DIV == 5) bus.i_value = 8'($urandom_range(0, 127));
            step();
            n_cmp++; if (bus.o_avg_valid !== exp_valid) begin n_fail++; $display("FAIL abort_post_valid cyc=%0d got %b want %b", cyc, bus.o_avg_valid, exp_valid); end
            if (bus.o_avg_valid === 1'b1) begin
                pulses++;
                n_cmp++; if (bus.o_average !== exp_avg) begin n_fail++; $display("FAIL abort_post_avg got %h want %h", bus.o_average, exp_avg); end
            end
        end
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL abort_post_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int npulse = 0;
        for (int i = 0; i < 60; i++) begin
            bus.i_value = 8'($urandom);
            step();
            n_cmp++; if (bus.o_avg_valid !== exp_valid) begin n_fail++; $display("FAIL b2b_valid cyc=%0d got %b want %b", cyc, bus.o_avg_valid, exp_valid); end
            if (bus.o_avg_valid === 1'b1) begin
                npulse++;
                n_cmp++; if (bus.o_average !== exp_avg) begin n_fail++; $display("FAIL b2b_avg cyc=%0d got %h want %h", cyc, bus.o_average, exp_avg); end
                n_cmp++; if (bus.o_bright !== exp_bright) begin n_fail++; $display("FAIL b2b_bright cyc=%0d got %b want %b", cyc, bus.o_bright, exp_bright); end
                if (last >= 0) begin
                    n_cmp++; if (cyc - last != SAMPLE_DIV) begin n_fail++; $display("FAIL b2b_period got %0d want %0d", cyc - last, SAMPLE_DIV); end
                end
                last = cyc;
            end
        end
        n_cmp++; if (npulse != 6) begin n_fail++; $display("FAIL b2b_count got %0d want 6", npulse); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_value = 8'h00;
        test_reset();
        test_first_fill();
        test_step_up();
        test_hysteresis();
        test_full_scale();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
